// File: rtl/wbu_csr_commit_ysyx_23060136.sv
// rtl/wbu_csr_commit_ysyx_23060136.sv - WBU CSR commit sequencer, sole driver of the CSR write port
module wbu_csr_commit_ysyx_23060136 #(
  parameter logic [31:0] ECALL_CAUSE = 32'hb,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [2:0]      in_csr_idx,
  input  logic [XLEN-1:0] in_csr_old,
  input  logic [XLEN-1:0] in_src,
  input  logic            in_src_is_zero,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            CSRWr,
  output logic [2:0]      WBU_csr_rd,
  output logic [XLEN-1:0] csr_busW,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_T_EPC, S_T_CAUSE, S_T_STAT, S_M_STAT
  } state_e;

  localparam logic [2:0] OP_RW    = 3'd1;
  localparam logic [2:0] OP_RS    = 3'd2;
  localparam logic [2:0] OP_RC    = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  localparam logic [2:0] IDX_MSTATUS = 3'd0;
  localparam logic [2:0] IDX_MEPC    = 3'd2;
  localparam logic [2:0] IDX_MCAUSE  = 3'd3;

  state_e          state_q, state_d;
  logic [XLEN-1:0] stat_q, stat_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            wr_q, wr_d;
  logic [2:0]      rd_q, rd_d;
  logic [XLEN-1:0] busw_q, busw_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] ecall_stat;
  logic [XLEN-1:0] mret_stat;
  logic            csr_wr_ok;

  // Outputs are registered, so each cycle computes what the next state will drive.
  always_comb begin
    wval = in_src;
    case (in_op)
      OP_RS:   wval = in_csr_old | in_src;
      OP_RC:   wval = in_csr_old & ~in_src;
      default: wval = in_src;
    endcase

    ecall_stat        = csr_mstatus;
    ecall_stat[7]     = csr_mstatus[3];
    ecall_stat[3]     = 1'b0;
    ecall_stat[12:11] = 2'b11;

    mret_stat        = csr_mstatus;
    mret_stat[3]     = csr_mstatus[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b11;

    // Read-only CSRs (idx 4, 5 and above) and set/clear with a zero mask never write.
    csr_wr_ok = (in_csr_idx < 3'd4) && ((in_op == OP_RW) || !in_src_is_zero);
  end

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    target_d = target_q;
    wr_d     = 1'b0;
    rd_d     = rd_q;
    busw_d   = busw_q;
    redir_d  = 1'b0;
    rpc_d    = rpc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (in_op)
            OP_RW, OP_RS, OP_RC: begin
              if (csr_wr_ok) begin
                state_d = S_WR;
                wr_d    = 1'b1;
                rd_d    = in_csr_idx;
                busw_d  = wval;
              end
            end
            OP_ECALL: begin
              state_d  = S_T_EPC;
              wr_d     = 1'b1;
              rd_d     = IDX_MEPC;
              busw_d   = in_pc;
              stat_d   = ecall_stat;
              target_d = csr_mtvec;
            end
            OP_MRET: begin
              state_d  = S_M_STAT;
              wr_d     = 1'b1;
              rd_d     = IDX_MSTATUS;
              busw_d   = mret_stat;
              target_d = csr_mepc;
              redir_d  = 1'b1;
              rpc_d    = csr_mepc;
            end
            default: ;
          endcase
        end
      end
      S_T_EPC: begin
        state_d = S_T_CAUSE;
        wr_d    = 1'b1;
        rd_d    = IDX_MCAUSE;
        busw_d  = ECALL_CAUSE;
      end
      S_T_CAUSE: begin
        state_d = S_T_STAT;
        wr_d    = 1'b1;
        rd_d    = IDX_MSTATUS;
        busw_d  = stat_q;
        redir_d = 1'b1;
        rpc_d   = target_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stat_q   <= '0;
      target_q <= '0;
      wr_q     <= 1'b0;
      rd_q     <= '0;
      busw_q   <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      target_q <= target_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      busw_q   <= busw_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign CSRWr          = wr_q;
  assign WBU_csr_rd     = rd_q;
  assign csr_busW       = busw_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_wbu_csr_commit_ysyx_23060136.sv
// tb/tb_wbu_csr_commit_ysyx_23060136.sv - directed bench for the WBU CSR commit sequencer
module tb_wbu_csr_commit_ysyx_23060136;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_csr_idx;
  logic [31:0] in_csr_old;
  logic [31:0] in_src;
  logic        in_src_is_zero;
  logic [31:0] in_pc;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        CSRWr;
  logic [2:0]  WBU_csr_rd;
  logic [31:0] csr_busW;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wbu_csr_commit_ysyx_23060136 dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_csr_idx     (in_csr_idx),
    .in_csr_old     (in_csr_old),
    .in_src         (in_src),
    .in_src_is_zero (in_src_is_zero),
    .in_pc          (in_pc),
    .csr_mstatus    (csr_mstatus),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .CSRWr          (CSRWr),
    .WBU_csr_rd     (WBU_csr_rd),
    .csr_busW       (csr_busW),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid       = 1'b0;
    in_op          = 3'd0;
    in_csr_idx     = 3'd0;
    in_csr_old     = 32'h0;
    in_src         = 32'h0;
    in_src_is_zero = 1'b0;
    in_pc          = 32'h0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] old,
                       input logic [31:0] src, input logic zero);
    in_valid       = 1'b1;
    in_op          = op;
    in_csr_idx     = idx;
    in_csr_old     = old;
    in_src         = src;
    in_src_is_zero = zero;
  endtask

  initial begin
    rst         = 1'b1;
    csr_mstatus = 32'h0;
    csr_mtvec   = 32'h0;
    csr_mepc    = 32'h0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_csrwr",  32'(CSRWr), 32'h0);
    chk("rst_rd",     32'(WBU_csr_rd), 32'h0);
    chk("rst_busw",   csr_busW, 32'h0);
    chk("rst_redir",  32'(redirect_valid), 32'h0);
    chk("rst_rpc",    redirect_pc, 32'h0);
    chk("rst_ready",  32'(in_ready), 32'h1);
    chk("rst_busy",   32'(busy), 32'h0);

    // RW to mtvec: one write on the following cycle
    issue(3'd1, 3'd1, 32'h0, 32'h8000_0100, 1'b0);
    tick();
    idle_inputs();
    chk("rw_csrwr", 32'(CSRWr), 32'h1);
    chk("rw_rd",    32'(WBU_csr_rd), 32'h1);
    chk("rw_busw",  csr_busW, 32'h8000_0100);
    chk("rw_ready", 32'(in_ready), 32'h0);
    chk("rw_busy",  32'(busy), 32'h1);
    tick();
    chk("rw_done_csrwr", 32'(CSRWr), 32'h0);
    chk("rw_done_ready", 32'(in_ready), 32'h1);
    chk("rw_hold_busw",  csr_busW, 32'h8000_0100);

    issue(3'd2, 3'd0, 32'h1800, 32'h8, 1'b0);
    tick();
    idle_inputs();
    chk("rs_csrwr", 32'(CSRWr), 32'h1);
    chk("rs_rd",    32'(WBU_csr_rd), 32'h0);
    chk("rs_busw",  csr_busW, 32'h1808);
    tick();

    issue(3'd2, 3'd0, 32'h1800, 32'h8, 1'b1);
    tick();
    idle_inputs();
    chk("rs_zero_csrwr", 32'(CSRWr), 32'h0);
    chk("rs_zero_ready", 32'(in_ready), 32'h1);
    chk("rs_zero_hold",  csr_busW, 32'h1808);

    issue(3'd3, 3'd0, 32'h1808, 32'h8, 1'b0);
    tick();
    idle_inputs();
    chk("rc_csrwr", 32'(CSRWr), 32'h1);
    chk("rc_busw",  csr_busW, 32'h1800);
    tick();

    issue(3'd1, 3'd4, 32'h0, 32'hdead_beef, 1'b0);
    tick();
    chk("rw_idx4_csrwr", 32'(CSRWr), 32'h0);
    chk("rw_idx4_ready", 32'(in_ready), 32'h1);
    issue(3'd1, 3'd5, 32'h0, 32'hdead_beef, 1'b0);
    tick();
    chk("rw_idx5_csrwr", 32'(CSRWr), 32'h0);
    chk("rw_idx5_ready", 32'(in_ready), 32'h1);

    // NONE ops and undefined opcodes retire every cycle
    for (int i = 0; i < 4; i++) begin
      issue((i < 2) ? 3'd0 : 3'd6 + 3'(i - 2), 3'd1, 32'h0, 32'h1234, 1'b0);
      chk("none_ready", 32'(in_ready), 32'h1);
      tick();
      chk("none_csrwr", 32'(CSRWr), 32'h0);
      chk("none_redir", 32'(redirect_valid), 32'h0);
    end
    idle_inputs();

    // ECALL: CSR inputs are scrambled after accept to prove targets were latched
    csr_mstatus = 32'h1808;
    csr_mtvec   = 32'h8000_0500;
    csr_mepc    = 32'h1111_1111;
    issue(3'd4, 3'd0, 32'h0, 32'h0, 1'b0);
    in_pc = 32'h8000_0040;
    tick();
    idle_inputs();
    csr_mstatus = 32'hffff_ffff;
    csr_mtvec   = 32'h0;
    chk("ecall_epc_csrwr", 32'(CSRWr), 32'h1);
    chk("ecall_epc_rd",    32'(WBU_csr_rd), 32'h2);
    chk("ecall_epc_busw",  csr_busW, 32'h8000_0040);
    chk("ecall_epc_redir", 32'(redirect_valid), 32'h0);
    chk("ecall_epc_ready", 32'(in_ready), 32'h0);
    tick();
    chk("ecall_cause_csrwr", 32'(CSRWr), 32'h1);
    chk("ecall_cause_rd",    32'(WBU_csr_rd), 32'h3);
    chk("ecall_cause_busw",  csr_busW, 32'hb);
    chk("ecall_cause_redir", 32'(redirect_valid), 32'h0);
    tick();
    chk("ecall_stat_csrwr", 32'(CSRWr), 32'h1);
    chk("ecall_stat_rd",    32'(WBU_csr_rd), 32'h0);
    chk("ecall_stat_busw",  csr_busW, 32'h1880);
    chk("ecall_stat_redir", 32'(redirect_valid), 32'h1);
    chk("ecall_stat_rpc",   redirect_pc, 32'h8000_0500);
    chk("ecall_stat_ready", 32'(in_ready), 32'h0);
    tick();
    chk("ecall_end_csrwr", 32'(CSRWr), 32'h0);
    chk("ecall_end_redir", 32'(redirect_valid), 32'h0);
    chk("ecall_end_ready", 32'(in_ready), 32'h1);

    csr_mstatus = 32'h1880;
    csr_mepc    = 32'h8000_0040;
    csr_mtvec   = 32'h8000_0500;
    issue(3'd5, 3'd0, 32'h0, 32'h0, 1'b0);
    tick();
    idle_inputs();
    csr_mepc = 32'h0;
    chk("mret_csrwr", 32'(CSRWr), 32'h1);
    chk("mret_rd",    32'(WBU_csr_rd), 32'h0);
    chk("mret_busw",  csr_busW, 32'h1888);
    chk("mret_redir", 32'(redirect_valid), 32'h1);
    chk("mret_rpc",   redirect_pc, 32'h8000_0040);
    chk("mret_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mret_end_csrwr", 32'(CSRWr), 32'h0);
    chk("mret_end_redir", 32'(redirect_valid), 32'h0);
    chk("mret_end_ready", 32'(in_ready), 32'h1);

    // Reset while the ECALL sequence sits in T_CAUSE
    csr_mstatus = 32'h1808;
    csr_mtvec   = 32'h8000_0500;
    issue(3'd4, 3'd0, 32'h0, 32'h0, 1'b0);
    in_pc = 32'h8000_0080;
    tick();
    idle_inputs();
    tick();
    chk("abort_tcause_rd", 32'(WBU_csr_rd), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_csrwr", 32'(CSRWr), 32'h0);
    chk("abort_rd",    32'(WBU_csr_rd), 32'h0);
    chk("abort_busw",  csr_busW, 32'h0);
    chk("abort_redir", 32'(redirect_valid), 32'h0);
    chk("abort_rpc",   redirect_pc, 32'h0);
    chk("abort_ready", 32'(in_ready), 32'h1);
    chk("abort_busy",  32'(busy), 32'h0);
    tick();
    chk("abort_after_csrwr", 32'(CSRWr), 32'h0);
    chk("abort_after_redir", 32'(redirect_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
